// File: rtl/div_vl.sv
// div_vl: variable-latency radix-2 restoring divider with a level-held
// start/valid handshake. Iterations = bit length of |dividend|.
module div_vl #(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] dvdnd,
    input  logic [WIDTH-1:0] dvsor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rmdr,
    input  logic             start,
    output logic             valid,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;       // captured dividend
    logic [WIDTH-1:0] b_q, b_d;       // captured divisor
    logic [WIDTH-1:0] dd_q, dd_d;     // left-aligned |dividend|, shifted out MSB first
    logic [WIDTH-1:0] dv_q, dv_d;     // |divisor|
    logic [WIDTH-1:0] pr_q, pr_d;     // partial remainder
    logic [WIDTH-1:0] qt_q, qt_d;     // quotient magnitude
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rmdr_q, rmdr_d;
    logic             valid_q, valid_d;
    logic             dz_q, dz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [CW-1:0]    nbits;
    logic [CW-1:0]    shamt;
    logic [WIDTH:0]   trial;

    // Operand magnitudes, dividend bit length and alignment shift for PREP
    always_comb begin
        a_neg = (SIGNED != 0) && a_q[WIDTH-1];
        b_neg = (SIGNED != 0) && b_q[WIDTH-1];
        abs_a = a_neg ? -a_q : a_q;
        abs_b = b_neg ? -b_q : b_q;
        nbits = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (abs_a[i]) begin
                nbits = CW'(i + 1);
            end
        end
        shamt = CW'(WIDTH) - nbits;
    end

    // One restoring step: bring in next dividend bit and trial-subtract
    always_comb begin
        trial = {pr_q, dd_q[WIDTH-1]} - {1'b0, dv_q};
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        dd_d    = dd_q;
        dv_d    = dv_q;
        pr_d    = pr_q;
        qt_d    = qt_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quot_d  = quot_q;
        rmdr_d  = rmdr_q;
        valid_d = valid_q;
        dz_d    = dz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = dvdnd;
                    b_d     = dvsor;
                    state_d = PREP;
                end
            end
            PREP: begin
                if (!start) begin
                    state_d = IDLE;
                end else begin
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    dv_d    = abs_b;
                    dd_d    = abs_a << shamt;
                    pr_d    = '0;
                    qt_d    = '0;
                    cnt_d   = nbits;
                    state_d = ((b_q == '0) || (nbits == '0)) ? FIX : ITER;
                end
            end
            ITER: begin
                if (!start) begin
                    state_d = IDLE;
                end else begin
                    if (!trial[WIDTH]) begin
                        pr_d = trial[WIDTH-1:0];
                        qt_d = {qt_q[WIDTH-2:0], 1'b1};
                    end else begin
                        pr_d = {pr_q[WIDTH-2:0], dd_q[WIDTH-1]};
                        qt_d = {qt_q[WIDTH-2:0], 1'b0};
                    end
                    dd_d  = {dd_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (!start) begin
                    state_d = IDLE;
                end else begin
                    if (b_q == '0) begin
                        quot_d = '1;
                        rmdr_d = a_q;
                        dz_d   = 1'b1;
                    end else begin
                        quot_d = qneg_q ? -qt_q : qt_q;
                        rmdr_d = rneg_q ? -pr_q : pr_q;
                        dz_d   = 1'b0;
                    end
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    valid_d = 1'b0;
                    dz_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dd_q    <= '0;
            dv_q    <= '0;
            pr_q    <= '0;
            qt_q    <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quot_q  <= '0;
            rmdr_q  <= '0;
            valid_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dd_q    <= dd_d;
            dv_q    <= dv_d;
            pr_q    <= pr_d;
            qt_q    <= qt_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quot_q  <= quot_d;
            rmdr_q  <= rmdr_d;
            valid_q <= valid_d;
            dz_q    <= dz_d;
        end
    end

    assign quot  = quot_q;
    assign rmdr  = rmdr_q;
    assign valid = valid_q;
    assign dz    = dz_q;

endmodule

// File: tb/tb_div_vl.sv
// Testbench for div_vl: signed and unsigned instances, queue scoreboard
// filled by the driver and drained by an independent monitor.
module tb_div_vl;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        int          e0;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] dvdnd, dvsor;
    logic        start_s, start_u;
    logic [31:0] quot_s, rmdr_s, quot_u, rmdr_u;
    logic        valid_s, dz_s, valid_u, dz_u;

    int   checks;
    int   errors;
    int   cyc;
    exp_t sq_s[$];
    exp_t sq_u[$];

    div_vl #(.WIDTH(32), .SIGNED(1)) u_s (
        .clock(clk), .reset(reset), .dvdnd(dvdnd), .dvsor(dvsor),
        .quot(quot_s), .rmdr(rmdr_s), .start(start_s), .valid(valid_s), .dz(dz_s)
    );

    div_vl #(.WIDTH(32), .SIGNED(0)) u_u (
        .clock(clk), .reset(reset), .dvdnd(dvdnd), .dvsor(dvsor),
        .quot(quot_u), .rmdr(rmdr_u), .start(start_u), .valid(valid_u), .dz(dz_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: magnitude division with plain arithmetic, then signs applied
    function automatic exp_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t            e;
        longint unsigned ua, ub, q, r;
        bit              na, nb;
        int              n;
        na = sgn && a[31];
        nb = sgn && b[31];
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (na) ua = 64'h1_0000_0000 - ua;
        if (nb) ub = 64'h1_0000_0000 - ub;
        n = 0;
        while ((ua >> n) != 0) n++;
        e.e0 = 0;
        if (b == 32'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            q    = ua / ub;
            r    = ua % ub;
            e.q  = (na ^ nb) ? 32'(-q) : 32'(q);
            e.r  = na ? 32'(-r) : 32'(r);
            e.dz = 1'b0;
        end
        e.lat = (b == 32'd0 || n == 0) ? 2 : n + 2;
        return e;
    endfunction

    // Monitor: compare on each rising valid, check hold while valid stays high
    initial begin
        exp_t        e;
        logic        pv_s, pv_u;
        logic [31:0] hq_s, hr_s, hq_u, hr_u;
        pv_s = 1'b0;
        pv_u = 1'b0;
        hq_s = '0; hr_s = '0; hq_u = '0; hr_u = '0;
        forever begin
            @(negedge clk);
            if (valid_s === 1'b1 && !pv_s) begin
                if (sq_s.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid_s actual=1 required=0");
                end else begin
                    e = sq_s.pop_front();
                    chk("quot_s", quot_s, e.q);
                    chk("rmdr_s", rmdr_s, e.r);
                    chk("dz_s", 32'(dz_s), 32'(e.dz));
                    chk("latency_s", 32'(cyc - e.e0), 32'(e.lat));
                end
                hq_s = quot_s;
                hr_s = rmdr_s;
            end else if (valid_s === 1'b1) begin
                chk("hold_quot_s", quot_s, hq_s);
                chk("hold_rmdr_s", rmdr_s, hr_s);
            end
            if (valid_u === 1'b1 && !pv_u) begin
                if (sq_u.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid_u actual=1 required=0");
                end else begin
                    e = sq_u.pop_front();
                    chk("quot_u", quot_u, e.q);
                    chk("rmdr_u", rmdr_u, e.r);
                    chk("dz_u", 32'(dz_u), 32'(e.dz));
                    chk("latency_u", 32'(cyc - e.e0), 32'(e.lat));
                end
                hq_u = quot_u;
                hr_u = rmdr_u;
            end else if (valid_u === 1'b1) begin
                chk("hold_quot_u", quot_u, hq_u);
                chk("hold_rmdr_u", rmdr_u, hr_u);
            end
            pv_s = (valid_s === 1'b1);
            pv_u = (valid_u === 1'b1);
        end
    end

    // One full operation; entered and left at a negedge
    task automatic run(input bit uns, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit mid_change);
        exp_t        e;
        logic        vld;
        logic [31:0] q0;
        int          t;
        e    = model(!uns, a, b);
        e.e0 = cyc + 1;
        dvdnd = a;
        dvsor = b;
        if (uns) begin
            start_u = 1'b1;
            sq_u.push_back(e);
        end else begin
            start_s = 1'b1;
            sq_s.push_back(e);
        end
        vld = 1'b0;
        for (t = 0; t < 60; t++) begin
            @(negedge clk);
            if (mid_change && t == 3) begin
                dvdnd = $urandom;
                dvsor = $urandom;
            end
            vld = uns ? valid_u : valid_s;
            if (vld === 1'b1) break;
        end
        if (vld !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=%0d required<=%0d", t, e.lat);
            if (uns) void'(sq_u.pop_front());
            else void'(sq_s.pop_front());
            start_s = 1'b0;
            start_u = 1'b0;
            @(negedge clk);
            return;
        end
        q0 = uns ? quot_u : quot_s;
        repeat (hold) @(negedge clk);
        start_s = 1'b0;
        start_u = 1'b0;
        @(negedge clk);
        chk("valid_clear", 32'(uns ? valid_u : valid_s), 32'd0);
        chk("dz_clear", 32'(uns ? dz_u : dz_s), 32'd0);
        chk("quot_kept", uns ? quot_u : quot_s, q0);
    endtask

    initial begin
        logic [31:0] a, b;
        bool_dummy: begin end
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        start_s = 1'b0;
        start_u = 1'b0;
        dvdnd   = '0;
        dvsor   = '0;
        repeat (3) @(negedge clk);
        chk("rst_quot", quot_s, 32'd0);
        chk("rst_rmdr", rmdr_s, 32'd0);
        chk("rst_valid", 32'(valid_s), 32'd0);
        chk("rst_dz", 32'(dz_s), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run(0, 32'd12345, 32'd1238, 3, 0);
        run(0, -32'sd34222, -32'sd1, 0, 0);
        run(0, -32'sd12345, 32'd10, 1, 0);
        run(0, 32'd7, 32'd0, 2, 0);
        run(0, 32'd0, 32'd5, 0, 0);
        run(0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run(1, 32'hFFFF_FFFF, 32'd1, 0, 0);
        run(0, 32'h7FFF_1234, 32'd77, 0, 1);
        run(1, 32'hDEAD_BEEF, 32'd0, 0, 0);

        // Abort: drop start during ITER, valid must never rise
        dvdnd   = 32'h4000_0000;
        dvsor   = 32'd3;
        start_s = 1'b1;
        repeat (4) @(negedge clk);
        start_s = 1'b0;
        a = 32'd0;
        repeat (40) begin
            @(negedge clk);
            if (valid_s === 1'b1) a = 32'd1;
        end
        chk("abort_no_valid", a, 32'd0);

        // Reset in the middle of an operation
        dvdnd   = 32'd15283110;
        dvsor   = 32'd3;
        start_s = 1'b1;
        repeat (5) @(negedge clk);
        reset   = 1'b1;
        start_s = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(valid_s), 32'd0);
        chk("midrst_quot", quot_s, 32'd0);
        chk("midrst_rmdr", rmdr_s, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run(0, 32'd100, 32'd7, 0, 0);

        // Randomised operations over a spread of dividend bit lengths
        for (int i = 0; i < 80; i++) begin
            a = $urandom >> $urandom_range(0, 31);
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) b = '0;
            if ($urandom_range(0, 12) == 0) a = '0;
            if ($urandom_range(0, 1) == 1) a = -a;
            if ($urandom_range(0, 1) == 1) b = -b;
            run(i[0], a, b, int'($urandom_range(0, 3)), $urandom_range(0, 4) == 0);
        end

        repeat (5) @(negedge clk);
        chk("queues_empty", 32'(sq_s.size() + sq_u.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/div_vl.md
Name: div_vl

Overview:
- Variable-latency sequential integer divider; the inverse companion of the multi_vl multiplier.
- Uses the same level-held start/valid handshake, so datapath control drives multiply and divide units identically.
- Radix-2 restoring division, one quotient bit per cycle.
- Early termination: iteration count equals the bit length of |dividend|, so small dividends finish fast.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SIGNED, 1, 1 = two's-complement operands and results; 0 = unsigned.

Ports:
- clock     input   1      rising-edge clock
- reset     input   1      synchronous, active-high
- dvdnd     input   WIDTH  dividend
- dvsor     input   WIDTH  divisor
- quot      output  WIDTH  quotient
- rmdr      output  WIDTH  remainder
- start     input   1      level request; held high until result consumed
- valid     output  1      result valid
- dz        output  1      divide-by-zero flag, qualified by valid

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; while it is sampled high, state goes to IDLE and quot, rmdr, valid and dz are all 0. Reset mid-operation aborts with no result.
- IDLE:
  - On an edge with start=1, register dvdnd/dvsor and go to PREP (call this edge E0).
  - Input changes after E0 are ignored until the next IDLE.
- PREP:
  - When SIGNED=1, record sign_q = sign(dvdnd) XOR sign(dvsor) and sign_r = sign(dvdnd).
  - Take absolute values as unsigned WIDTH bits (|-2^(WIDTH-1)| = 2^(WIDTH-1)).
  - N = bit length of |dvdnd| (0 when dvdnd = 0). Left-align |dvdnd| so its MSB is at WIDTH-1.
  - Clear partial remainder and quotient.
  - If divisor = 0 or N = 0, go to FIX; otherwise go to ITER with counter = N.
- ITER (one step per cycle):
  - Shift the next dividend bit into the partial remainder and trial-subtract |divisor| using a WIDTH+1-bit subtractor.
  - If the result is non-negative, keep the difference and set quotient bit 1; otherwise restore and set bit 0.
  - Decrement the counter; at 0 go to FIX.
- FIX:
  - Apply signs: quot negated if sign_q, rmdr negated if sign_r. Truncation is toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: quot = all ones, rmdr = original dividend, dz = 1.
  - Go to DONE, registering outputs.
- DONE:
  - valid=1; quot, rmdr and dz are held stable.
  - Stay in DONE while start=1. On an edge with start=0, clear valid and dz and return to IDLE. quot/rmdr keep their last values.
- Latency: valid is first high after edge E0+N+2, i.e. N+2 cycles. Divide by zero and zero dividend take 2 cycles. Maximum is WIDTH+2.
- Restart rule: a new operation requires start to be low for at least one edge. Keeping start high after DONE never restarts.
- Abort: if start is sampled 0 in PREP, ITER or FIX, return to IDLE with valid never asserted.
- Overflow: SIGNED, -2^(WIDTH-1) / -1 gives quot = 0x80000000, rmdr = 0, dz = 0 (wraps, no flag).
- Unsigned mode (SIGNED=0): no sign handling; N is computed on the raw dividend.
- Arithmetic: all arithmetic is modulo 2^WIDTH except the WIDTH+1-bit trial subtract. The iteration counter is clog2(WIDTH+1) bits.

Test Plan:
- Basic positive: dvdnd=12345, dvsor=1238, start held -> quot=9, rmdr=1203, dz=0, valid first high 16 cycles after E0 (N=14); valid stays high until start drops, then clears next edge.
- Negative operands: -34222 / -1 -> quot=34222, rmdr=0, latency 18 (N=16); then -12345 / 10 -> quot=-1234, rmdr=-5, latency 16.
- Divide by zero: 7 / 0 -> quot=0xFFFFFFFF, rmdr=7, dz=1, latency 2. Follow with 0 / 5 -> quot=0, rmdr=0, dz=0, latency 2.
- Overflow/max latency: 0x80000000 / 0xFFFFFFFF -> quot=0x80000000, rmdr=0, latency 34. Also 0xFFFFFFFF / 1 with SIGNED=0 -> quot=0xFFFFFFFF, latency 34.
- Handshake:
  - Change dvdnd/dvsor mid-ITER -> result reflects the operands at E0.
  - Drop start during ITER -> valid never rises and the FSM returns to IDLE.
  - Back-to-back operations with a one-cycle start gap -> both results correct.
- Reset mid-op: assert reset during ITER of 1238*12345 / 3 -> next edge valid=0, quot=0, rmdr=0, state IDLE. A following 100 / 7 -> quot=14, rmdr=2, latency 9.
